// File: rtl/qpsk_demodulate_if.sv
// Sample/decision bus of the QPSK demodulator.
// The master side supplies the composite samples and the reference carriers.
// The slave side (the demodulator) returns the bit decisions and the sync flag.
interface qpsk_demodulate_if;
  logic              sample_valid;
  logic              sym_start;
  logic        [8:0] qpsk_in;
  logic signed [7:0] i_ref;
  logic signed [7:0] q_ref;
  logic              sym_valid;
  logic              i_bit;
  logic              q_bit;
  logic              sync_err;

  modport master (
    output sample_valid, sym_start, qpsk_in, i_ref, q_ref,
    input  sym_valid, i_bit, q_bit, sync_err
  );

  modport slave (
    input  sample_valid, sym_start, qpsk_in, i_ref, q_ref,
    output sym_valid, i_bit, q_bit, sync_err
  );
endinterface

// File: rtl/qpsk_demodulate.sv
// QPSK demodulator.
// Removes the DC offset from the composite sample and correlates it against the
// local I/Q carriers over one symbol. The sign of each correlation becomes a bit,
// and a zero correlation decides 1.
module qpsk_demodulate #(
  parameter int unsigned SPS    = 8,
  parameter int unsigned OFFSET = 255,
  parameter int unsigned ACC_W  = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  qpsk_demodulate_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(SPS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SPS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                   state, state_nx;
  logic        [CNT_W-1:0]  cnt, cnt_nx;
  logic signed [ACC_W-1:0]  acc_i, acc_i_nx, acc_q, acc_q_nx;
  logic                     sym_valid, sym_valid_nx;
  logic                     i_bit, i_bit_nx, q_bit, q_bit_nx;
  logic                     sync_err, sync_err_nx;

  logic        [9:0]        s_raw;
  logic signed [9:0]        s;
  logic signed [17:0]       pi, pq;
  logic signed [ACC_W-1:0]  pi_ext, pq_ext, sum_i, sum_q;

  // Offset removal, per-sample products and the running sums including this sample.
  always_comb begin
    s_raw  = {1'b0, bus.qpsk_in} - 10'(OFFSET);
    s      = signed'(s_raw);
    pi     = 18'(s) * 18'(bus.i_ref);
    pq     = 18'(s) * 18'(bus.q_ref);
    pi_ext = {{(ACC_W-18){pi[17]}}, pi};
    pq_ext = {{(ACC_W-18){pq[17]}}, pq};
    sum_i  = acc_i + pi_ext;
    sum_q  = acc_q + pq_ext;
  end

  // Next-state and next-datapath logic for symbol framing and decisions.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    acc_i_nx     = acc_i;
    acc_q_nx     = acc_q;
    sym_valid_nx = 1'b0;
    i_bit_nx     = i_bit;
    q_bit_nx     = q_bit;
    sync_err_nx  = sync_err;
    unique case (state)
      IDLE: begin
        if (bus.sample_valid && bus.sym_start) begin
          state_nx = RUN;
          acc_i_nx = pi_ext;
          acc_q_nx = pq_ext;
          cnt_nx   = CNT_W'(1);
        end
      end
      RUN: begin
        if (bus.sample_valid) begin
          if (bus.sym_start) begin
            // A restart with samples already gathered drops the partial symbol.
            if (cnt != '0) sync_err_nx = 1'b1;
            acc_i_nx = pi_ext;
            acc_q_nx = pq_ext;
            cnt_nx   = CNT_W'(1);
          end else if (cnt == LAST) begin
            i_bit_nx     = ~sum_i[ACC_W-1];
            q_bit_nx     = ~sum_q[ACC_W-1];
            sym_valid_nx = 1'b1;
            acc_i_nx     = '0;
            acc_q_nx     = '0;
            cnt_nx       = '0;
          end else begin
            acc_i_nx = sum_i;
            acc_q_nx = sum_q;
            cnt_nx   = cnt + CNT_W'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc_i     <= '0;
      acc_q     <= '0;
      sym_valid <= 1'b0;
      i_bit     <= 1'b0;
      q_bit     <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      acc_i     <= acc_i_nx;
      acc_q     <= acc_q_nx;
      sym_valid <= sym_valid_nx;
      i_bit     <= i_bit_nx;
      q_bit     <= q_bit_nx;
      sync_err  <= sync_err_nx;
    end
  end

  assign bus.sym_valid = sym_valid;
  assign bus.i_bit     = i_bit;
  assign bus.q_bit     = q_bit;
  assign bus.sync_err  = sync_err;

endmodule
